// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// master = fetch/decoder side, slave = the queue itself.
interface inst_queue_if;
  logic        push_en;
  logic [31:0] push_inst;
  logic [31:0] push_pc;
  logic        IQ_isfull;
  logic        Get_Inst;
  logic [31:0] Inst_out;
  logic [31:0] pc_out;
  logic        en_out;
  logic        IQ_isempty;

  modport master (
    output push_en, push_inst, push_pc, Get_Inst,
    input  IQ_isfull, IQ_isempty, Inst_out, pc_out, en_out
  );

  modport slave (
    input  push_en, push_inst, push_pc, Get_Inst,
    output IQ_isfull, IQ_isempty, Inst_out, pc_out, en_out
  );
endinterface

// File: rtl/inst_queue.sv
// Circular {instruction, pc} FIFO between fetch and decode, flushed by clear.
// Optional empty-queue bypass enabled by defining IQ_BYPASS_EN.
module inst_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         clear,
  inst_queue_if.slave  iq
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [31:0]     inst_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;
  logic [31:0]     inst_q;
  logic [31:0]     pc_q;
  logic            en_q;

  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;
  logic bypass;
  logic wr_en;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = iq.push_en && !full;
  assign pop_ok  = iq.Get_Inst && !empty;

`ifdef IQ_BYPASS_EN
  assign bypass = empty && iq.push_en && iq.Get_Inst;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed pair is handed straight to the decoder and never stored.
  assign wr_en = rdy_in && !clear && push_ok && !bypass;

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      inst_mem[tail] <= iq.push_inst;
      pc_mem[tail]   <= iq.push_pc;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      inst_q <= '0;
      pc_q   <= '0;
      en_q   <= 1'b0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      en_q  <= 1'b0;
    end else if (rdy_in) begin
      if (bypass) begin
        inst_q <= iq.push_inst;
        pc_q   <= iq.push_pc;
        en_q   <= 1'b1;
      end else begin
        if (push_ok) begin
          tail <= tail + ADDR_W'(1);
        end
        if (pop_ok) begin
          inst_q <= inst_mem[head];
          pc_q   <= pc_mem[head];
          head   <= head + ADDR_W'(1);
          en_q   <= 1'b1;
        end else begin
          en_q <= 1'b0;
        end
        unique case ({push_ok, pop_ok})
          2'b10:   count <= count + (ADDR_W+1)'(1);
          2'b01:   count <= count - (ADDR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign iq.IQ_isfull  = full;
  assign iq.IQ_isempty = empty;
  assign iq.Inst_out   = inst_q;
  assign iq.pc_out     = pc_q;
  assign iq.en_out     = en_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_inst_queue;

  localparam int unsigned DEPTH = 16;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic clear  = 1'b0;

  inst_queue_if iq ();

  inst_queue #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .iq     (iq.slave)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: a plain queue of {inst, pc} pairs.
  logic [63:0] q [$];
  logic [31:0] m_inst = '0;
  logic [31:0] m_pc   = '0;
  logic        m_en   = 1'b0;

  initial begin
    forever begin
      @(posedge clk_in or negedge rst_in);
      if (!rst_in) begin
        q.delete();
        m_inst = '0;
        m_pc   = '0;
        m_en   = 1'b0;
      end else if (clear) begin
        q.delete();
        m_en = 1'b0;
      end else if (rdy_in) begin
        automatic bit was_full  = (q.size() == DEPTH);
        automatic bit was_empty = (q.size() == 0);
        automatic bit byp = 1'b0;
`ifdef IQ_BYPASS_EN
        byp = was_empty && iq.push_en && iq.Get_Inst;
`endif
        if (byp) begin
          m_inst = iq.push_inst;
          m_pc   = iq.push_pc;
          m_en   = 1'b1;
        end else begin
          if (iq.Get_Inst && !was_empty) begin
            automatic logic [63:0] e = q.pop_front();
            m_inst = e[63:32];
            m_pc   = e[31:0];
            m_en   = 1'b1;
          end else begin
            m_en = 1'b0;
          end
          if (iq.push_en && !was_full) q.push_back({iq.push_inst, iq.push_pc});
        end
      end
    end
  end

  // Continuous compare on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk_in);
      n_vec++;
      if (iq.en_out !== m_en || iq.pc_out !== m_pc || iq.Inst_out !== m_inst ||
          iq.IQ_isempty !== (q.size() == 0) || iq.IQ_isfull !== (q.size() == DEPTH)) begin
        n_bad++;
        $display("FAIL model t=%0t: got en=%b pc=%h inst=%h empty=%b full=%b, want en=%b pc=%h inst=%h empty=%b full=%b",
                 $time, iq.en_out, iq.pc_out, iq.Inst_out, iq.IQ_isempty, iq.IQ_isfull,
                 m_en, m_pc, m_inst, (q.size() == 0), (q.size() == DEPTH));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic drive(input bit pe, input logic [31:0] pc, input bit get);
    iq.push_en   = pe;
    iq.push_pc   = pc;
    iq.push_inst = inst_of(pc);
    iq.Get_Inst  = get;
  endtask

  initial begin
    drive(0, '0, 0);
    #1 check("reset_en", {31'd0, iq.en_out}, 32'd0);
    check("reset_empty", {31'd0, iq.IQ_isempty}, 32'd1);
    step();
    step();
    rst_in = 1'b1;
    step();

    // Fill to 16, then a 17th push that must be dropped.
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'(i * 4), 0);
      step();
    end
    check("fill_full", {31'd0, iq.IQ_isfull}, 32'd1);
    drive(1, 32'h40, 0);
    step();
    check("overflow_full", {31'd0, iq.IQ_isfull}, 32'd1);
    check("overflow_no_en", {31'd0, iq.en_out}, 32'd0);

    // Drain in order.
    drive(0, '0, 1);
    for (int i = 0; i < 16; i++) begin
      step();
      check("drain_en", {31'd0, iq.en_out}, 32'd1);
      check("drain_pc", iq.pc_out, 32'(i * 4));
    end
    check("drain_empty", {31'd0, iq.IQ_isempty}, 32'd1);
    step();
    check("drain_extra_en", {31'd0, iq.en_out}, 32'd0);
    check("drain_no_0x40", iq.pc_out, 32'h3C);

    // Concurrent push/pop at count 5; pointers wrap past 15.
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h200 + 32'(i * 4), 0);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h200 + 32'((i + 5) * 4), 1);
      step();
      check("conc_en", {31'd0, iq.en_out}, 32'd1);
      check("conc_pc", iq.pc_out, 32'h200 + 32'(i * 4));
      check("conc_not_empty", {31'd0, iq.IQ_isempty}, 32'd0);
    end
    drive(0, '0, 1);
    for (int i = 20; i < 25; i++) begin
      step();
      check("conc_tail_pc", iq.pc_out, 32'h200 + 32'(i * 4));
    end
    check("conc_empty", {31'd0, iq.IQ_isempty}, 32'd1);

    // Clear mid-stream with push and pop asserted.
    for (int i = 0; i < 7; i++) begin
      drive(1, 32'h300 + 32'(i * 4), 0);
      step();
    end
    drive(1, 32'h3FC, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_en", {31'd0, iq.en_out}, 32'd0);
    check("clear_empty", {31'd0, iq.IQ_isempty}, 32'd1);
    check("clear_pc_hold", iq.pc_out, 32'h260);
    drive(0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("clear_no_pop", {31'd0, iq.en_out}, 32'd0);
    end

    // rdy_in low for 3 cycles right after a pop.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h400 + 32'(i * 4), 0);
      step();
    end
    drive(0, '0, 1);
    step();
    check("rdy_pop_pc", iq.pc_out, 32'h400);
    drive(1, 32'h500, 1);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rdy_hold_en", {31'd0, iq.en_out}, 32'd1);
      check("rdy_hold_pc", iq.pc_out, 32'h400);
    end
    rdy_in = 1'b1;
    drive(0, '0, 1);
    step();
    check("rdy_resume_pc", iq.pc_out, 32'h404);
    step();
    check("rdy_resume_pc2", iq.pc_out, 32'h408);
    step();
    check("rdy_drained_en", {31'd0, iq.en_out}, 32'd0);
    check("rdy_drained_empty", {31'd0, iq.IQ_isempty}, 32'd1);

    // Empty queue: push 0x100 with Get_Inst held.
    drive(1, 32'h100, 1);
    step();
    drive(0, '0, 1);
`ifdef IQ_BYPASS_EN
    check("byp_en", {31'd0, iq.en_out}, 32'd1);
    check("byp_pc", iq.pc_out, 32'h100);
    check("byp_empty", {31'd0, iq.IQ_isempty}, 32'd1);
`else
    check("nobyp_en0", {31'd0, iq.en_out}, 32'd0);
    check("nobyp_not_empty", {31'd0, iq.IQ_isempty}, 32'd0);
    step();
    check("nobyp_en1", {31'd0, iq.en_out}, 32'd1);
    check("nobyp_pc", iq.pc_out, 32'h100);
    check("nobyp_inst", iq.Inst_out, inst_of(32'h100));
    check("nobyp_empty", {31'd0, iq.IQ_isempty}, 32'd1);
`endif

    // Asynchronous reset in mid-cycle while a strobe is up.
    drive(1, 32'h600, 0);
    step();
    drive(1, 32'h604, 1);
    step();
    check("prereset_en", {31'd0, iq.en_out}, 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check("areset_en", {31'd0, iq.en_out}, 32'd0);
    check("areset_pc", iq.pc_out, 32'd0);
    check("areset_inst", iq.Inst_out, 32'd0);
    check("areset_empty", {31'd0, iq.IQ_isempty}, 32'd1);
    check("areset_full", {31'd0, iq.IQ_isfull}, 32'd0);
    drive(0, '0, 0);
    step();
    rst_in = 1'b1;
    step();
    check("postreset_empty", {31'd0, iq.IQ_isempty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
